// File: rtl/eth_pkg.sv
// Shared definitions for the GMII transmit framer.
// State encoding and framing constants.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        TX_DATA,
        TX_PAD,
        TX_FCS,
        IFG,
        FINISH
    } state_t;

    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [31:0] POLY_REFL   = 32'hEDB8_8320;

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte step of the Ethernet CRC-32, reflected form.
// Purely combinational; shared with the receive path.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // Eight LSB-first shift/xor steps of the reflected polynomial.
    always_comb begin
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/ethtransmit.sv
// GMII transmit framer: preamble, SFD, payload, pad, FCS, IFG.
// All state changes on the falling edge of the TX clock.
module ethtransmit
    import eth_pkg::*;
#(
    parameter int PRE_LEN = 7,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int IFG_LEN = 12
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        txena,
    input  logic        txreq,
    input  logic [10:0] txcntb,
    output logic [9:0]  txbaddr,
    input  logic [15:0] txbdata,
    output logic [7:0]  dataout,
    output logic        txen,
    output logic        txer,
    output logic        txbusy,
    output logic        txrdy,
    output logic        err_len
);

    localparam logic [4:0]  PRE_LAST = 5'(PRE_LEN - 1);
    localparam logic [4:0]  IFG_LAST = 5'(IFG_LEN - 1);
    localparam logic [10:0] MIN_CNT  = 11'(MIN_LEN);
    localparam logic [10:0] MIN_LAST = 11'(MIN_LEN - 1);
    localparam logic [10:0] MAX_CNT  = 11'(MAX_LEN);

    state_t      state_q, state_n;
    logic [7:0]  dout_q, dout_n;
    logic        txen_q, txen_n;
    logic [9:0]  addr_q, addr_n;
    logic [15:0] word_q, word_n;
    logic [4:0]  cnt_q, cnt_n;
    logic [10:0] bcnt_q, bcnt_n;
    logic [10:0] len_q, len_n;
    logic [31:0] crc_q, crc_n;
    logic        busy_q, busy_n;
    logic        rdy_q, rdy_n;
    logic        errl_q, errl_n;

    logic [7:0]  feed;
    logic [31:0] crc_step;
    logic [31:0] fcs;
    logic        last_data;

    assign fcs       = ~crc_q;
    assign last_data = (bcnt_q == len_q - 11'd1);

    // Byte that enters the CRC on the coming edge (0 for pad).
    always_comb begin
        feed = 8'h00;
        if (state_q == SFD) begin
            feed = word_q[7:0];
        end else if (state_q == TX_DATA && !last_data) begin
            feed = bcnt_q[0] ? word_q[7:0] : word_q[15:8];
        end
    end

    eth_crc32_byte u_crc (
        .crc_in  (crc_q),
        .data    (feed),
        .crc_out (crc_step)
    );

    // Next-state and next-output logic; registers hold what is on the wire.
    always_comb begin
        state_n = state_q;
        dout_n  = dout_q;
        txen_n  = txen_q;
        addr_n  = addr_q;
        word_n  = word_q;
        cnt_n   = cnt_q;
        bcnt_n  = bcnt_q;
        len_n   = len_q;
        crc_n   = crc_q;
        busy_n  = busy_q;
        rdy_n   = rdy_q;
        errl_n  = errl_q;
        unique case (state_q)
            IDLE: begin
                dout_n = 8'h00;
                txen_n = 1'b0;
                addr_n = 10'd0;
                cnt_n  = 5'd0;
                bcnt_n = 11'd0;
                crc_n  = CRC_INIT;
                if (txreq && txena && !rdy_q) begin
                    if (txcntb == 11'd0 || txcntb > MAX_CNT) begin
                        errl_n  = 1'b1;
                        rdy_n   = 1'b1;
                        state_n = FINISH;
                    end else begin
                        errl_n  = 1'b0;
                        len_n   = txcntb;
                        busy_n  = 1'b1;
                        txen_n  = 1'b1;
                        dout_n  = PRE_BYTE;
                        state_n = PREAMBLE;
                    end
                end
            end
            PREAMBLE: begin
                if (cnt_q == PRE_LAST) begin
                    // Word 0 has been on txbdata since IDLE; start fetching word 1.
                    dout_n  = SFD_BYTE;
                    word_n  = txbdata;
                    addr_n  = 10'd1;
                    cnt_n   = 5'd0;
                    state_n = SFD;
                end else begin
                    dout_n = PRE_BYTE;
                    cnt_n  = cnt_q + 5'd1;
                end
            end
            SFD: begin
                dout_n  = word_q[7:0];
                bcnt_n  = 11'd0;
                crc_n   = crc_step;
                state_n = TX_DATA;
            end
            TX_DATA: begin
                if (last_data) begin
                    if (len_q < MIN_CNT) begin
                        dout_n  = 8'h00;
                        bcnt_n  = bcnt_q + 11'd1;
                        crc_n   = crc_step;
                        state_n = TX_PAD;
                    end else begin
                        dout_n  = fcs[7:0];
                        cnt_n   = 5'd0;
                        state_n = TX_FCS;
                    end
                end else if (!bcnt_q[0]) begin
                    // High byte goes out; the next word is already on txbdata.
                    dout_n = word_q[15:8];
                    word_n = txbdata;
                    addr_n = addr_q + 10'd1;
                    bcnt_n = bcnt_q + 11'd1;
                    crc_n  = crc_step;
                end else begin
                    dout_n = word_q[7:0];
                    bcnt_n = bcnt_q + 11'd1;
                    crc_n  = crc_step;
                end
            end
            TX_PAD: begin
                if (bcnt_q == MIN_LAST) begin
                    dout_n  = fcs[7:0];
                    cnt_n   = 5'd0;
                    state_n = TX_FCS;
                end else begin
                    dout_n = 8'h00;
                    bcnt_n = bcnt_q + 11'd1;
                    crc_n  = crc_step;
                end
            end
            TX_FCS: begin
                if (cnt_q == 5'd3) begin
                    dout_n  = 8'h00;
                    txen_n  = 1'b0;
                    cnt_n   = 5'd0;
                    state_n = IFG;
                end else begin
                    cnt_n = cnt_q + 5'd1;
                    case (cnt_q)
                        5'd0:    dout_n = fcs[15:8];
                        5'd1:    dout_n = fcs[23:16];
                        default: dout_n = fcs[31:24];
                    endcase
                end
            end
            IFG: begin
                if (cnt_q == IFG_LAST) begin
                    cnt_n   = 5'd0;
                    busy_n  = 1'b0;
                    rdy_n   = 1'b1;
                    state_n = FINISH;
                end else begin
                    cnt_n = cnt_q + 5'd1;
                end
            end
            FINISH: begin
                busy_n = 1'b0;
                if (!txreq) begin
                    rdy_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register, falling edge, asynchronous clear.
    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            dout_q  <= 8'h00;
            txen_q  <= 1'b0;
            addr_q  <= 10'd0;
            word_q  <= 16'h0000;
            cnt_q   <= 5'd0;
            bcnt_q  <= 11'd0;
            len_q   <= 11'd0;
            crc_q   <= CRC_INIT;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            errl_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            dout_q  <= dout_n;
            txen_q  <= txen_n;
            addr_q  <= addr_n;
            word_q  <= word_n;
            cnt_q   <= cnt_n;
            bcnt_q  <= bcnt_n;
            len_q   <= len_n;
            crc_q   <= crc_n;
            busy_q  <= busy_n;
            rdy_q   <= rdy_n;
            errl_q  <= errl_n;
        end
    end

    assign dataout = dout_q;
    assign txen    = txen_q;
    assign txer    = 1'b0;
    assign txbaddr = addr_q;
    assign txbusy  = busy_q;
    assign txrdy   = rdy_q;
    assign err_len = errl_q;

endmodule

// File: tb/tb_ethtransmit.sv
// Bench for ethtransmit: expected wire bytes are queued by stimulus,
// a monitor pops and compares every txen byte and checks frame length/residue.
module tb_ethtransmit;
    import eth_pkg::*;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        txena = 1'b0;
    logic        txreq = 1'b0;
    logic [10:0] txcntb = 11'd0;
    logic [9:0]  txbaddr;
    logic [15:0] txbdata;
    logic [7:0]  dataout;
    logic        txen, txer, txbusy, txrdy, err_len;

    logic [31:0] u_in, u_out;
    logic [7:0]  u_dat;

    int total = 0;
    int bad = 0;

    typedef struct {
        int len;
        bit res;
    } fr_t;

    logic [7:0]  exp_q[$];
    fr_t         fr_q[$];
    logic [15:0] mem[1024];

    always #4 clk = ~clk;

    ethtransmit dut (
        .clk     (clk),
        .clr     (clr),
        .txena   (txena),
        .txreq   (txreq),
        .txcntb  (txcntb),
        .txbaddr (txbaddr),
        .txbdata (txbdata),
        .dataout (dataout),
        .txen    (txen),
        .txer    (txer),
        .txbusy  (txbusy),
        .txrdy   (txrdy),
        .err_len (err_len)
    );

    eth_crc32_byte u_crc (
        .crc_in  (u_in),
        .data    (u_dat),
        .crc_out (u_out)
    );

    // Buffer RAM with one clock of read latency.
    always @(negedge clk) txbdata <= mem[txbaddr];

    function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31 - i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int len, input int cut);
        logic [7:0] q[$];
        logic [31:0] c;
        logic [7:0] b;
        logic [15:0] w;
        int n;
        fr_t f;
        for (int i = 0; i < 7; i++) q.push_back(8'h55);
        q.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        n = (len < 60) ? 60 : len;
        for (int i = 0; i < n; i++) begin
            w = mem[i / 2];
            if (i >= len) b = 8'h00;
            else if (i % 2 == 1) b = w[15:8];
            else b = w[7:0];
            q.push_back(b);
            c = crc8(c, b);
        end
        c = ~c;
        q.push_back(c[7:0]);
        q.push_back(c[15:8]);
        q.push_back(c[23:16]);
        q.push_back(c[31:24]);
        if (cut > 0) begin
            for (int i = 0; i < cut; i++) exp_q.push_back(q[i]);
            f.len = cut;
            f.res = 1'b0;
        end else begin
            foreach (q[i]) exp_q.push_back(q[i]);
            f.len = q.size();
            f.res = 1'b1;
        end
        fr_q.push_back(f);
    endtask

    int          fbytes = 0;
    logic [31:0] rc;
    logic        prev_txen = 1'b0;
    logic [7:0]  e_byte;
    fr_t         e_fr;

    // Monitor: compare each transmitted byte and close out each frame.
    always @(posedge clk) begin
        if (txen === 1'b1) begin
            if (fbytes == 0) rc = 32'hFFFFFFFF;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_byte: got %02h want none", dataout);
            end else begin
                e_byte = exp_q.pop_front();
                check($sformatf("byte%0d", fbytes), {24'h0, dataout}, {24'h0, e_byte});
            end
            if (fbytes >= 8) rc = crc8(rc, dataout);
            fbytes++;
        end else if (prev_txen) begin
            if (fr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_frame: got len %0d want none", fbytes);
            end else begin
                e_fr = fr_q.pop_front();
                check("frame_len", fbytes, e_fr.len);
                if (e_fr.res) check("residue", bitrev(rc), CRC_RESIDUE);
            end
            fbytes = 0;
        end
        prev_txen = txen;
    end

    task automatic wait_txen(input logic lvl, input int maxc, input string name);
        int n;
        n = 0;
        while (txen !== lvl && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, {31'h0, txen}, {31'h0, lvl});
    endtask

    task automatic wait_rdy(input int maxc, output int n);
        n = 0;
        while (txrdy !== 1'b1 && n < maxc) begin
            @(posedge clk);
            #1;
            if (txrdy !== 1'b1) n++;
        end
        check("rdy_timeout", {31'h0, txrdy}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] errlens[2];
        string s;
        int n;
        logic seen;
        for (int k = 0; k < 1024; k++) mem[k] = {8'(2 * k + 1), 8'(2 * k)};
        errlens[0] = 11'd0;
        errlens[1] = 11'd1515;

        repeat (3) @(posedge clk);
        #1;
        check("rst_txen", {31'h0, txen}, 0);
        check("rst_dout", {24'h0, dataout}, 0);
        check("rst_addr", {22'h0, txbaddr}, 0);
        check("rst_busy", {31'h0, txbusy}, 0);
        check("rst_rdy", {31'h0, txrdy}, 0);
        check("rst_errl", {31'h0, err_len}, 0);
        check("rst_txer", {31'h0, txer}, 0);
        clr = 1'b0;

        s = "123456789";
        u_in = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) begin
            u_dat = s[i];
            #1;
            u_in = u_out;
        end
        check("crc_unit", ~u_in, 32'hCBF43926);

        txena = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            txcntb = errlens[i];
            txreq = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            check("err_len", {31'h0, err_len}, 1);
            check("err_rdy", {31'h0, txrdy}, 1);
            check("err_busy", {31'h0, txbusy}, 0);
            txreq = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("err_rdy_clr", {31'h0, txrdy}, 0);
        end

        txcntb = 11'd64;
        push_frame(64, 0);
        txreq = 1'b1;
        wait_txen(1'b1, 20, "f64_start");
        wait_txen(1'b0, 200, "f64_end");
        wait_rdy(50, n);
        check("ifg_cycles", n + 1, 12);
        check("f64_errl", {31'h0, err_len}, 0);
        check("f64_busy", {31'h0, txbusy}, 0);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            seen |= txen;
        end
        check("no_refire", {31'h0, seen}, 0);
        check("rdy_held", {31'h0, txrdy}, 1);
        txreq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rdy_drop", {31'h0, txrdy}, 0);

        txcntb = 11'd5;
        push_frame(5, 0);
        txreq = 1'b1;
        wait_txen(1'b1, 20, "f5_start");
        txena = 1'b0;
        wait_txen(1'b0, 200, "f5_end");
        wait_rdy(50, n);
        txreq = 1'b0;
        txena = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        txcntb = 11'd64;
        push_frame(64, 28);
        txreq = 1'b1;
        n = 0;
        while (fbytes < 28 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_reach", fbytes, 28);
        clr = 1'b1;
        #1;
        check("abort_txen", {31'h0, txen}, 0);
        check("abort_busy", {31'h0, txbusy}, 0);
        check("abort_addr", {22'h0, txbaddr}, 0);
        txreq = 1'b0;
        repeat (2) @(posedge clk);
        clr = 1'b0;
        push_frame(64, 0);
        txreq = 1'b1;
        wait_txen(1'b1, 20, "fresh_start");
        wait_txen(1'b0, 200, "fresh_end");
        wait_rdy(50, n);
        txreq = 1'b0;
        repeat (2) @(posedge clk);

        txena = 1'b0;
        txreq = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            seen |= txen;
        end
        check("dis_busy", {31'h0, txbusy}, 0);
        check("dis_txen", {31'h0, seen}, 0);
        txreq = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("exp_left", exp_q.size(), 0);
        check("frames_left", fr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
